uart_tx_fifo: RTL

Buffered, parametrised UART transmitter. It replaces the single-character, ready-gated uart_tx path with a write FIFO that feeds a built-in serializer. Upstream logic (button/char selectors, message generators) can push bursts of characters without polling `ready`. Frame format, baud rate, word width and queue depth are set at elaboration.

---
 rtl/uart_tx_fifo.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: write FIFO feeding an 8N1-style serializer.
// Optional parity stage enabled by defining UART_TX_FIFO_PARITY_EN.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
`ifdef UART_TX_FIFO_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          wr_en,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic                          uart_tx,
  output logic                          busy
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(STOP_BITS * DIV + 1);
  localparam int IW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * DIV - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_FIFO_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q, count_d;
  logic                 full_q, full_d;
  logic                 ovf_q, ovf_d;
  logic                 push, pop;

  state_t               state_q;
  logic [CW-1:0]        baud_q;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tx_q, busy_q;

  assign push = wr_en && !full_q;
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  assign full     = full_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign uart_tx  = tx_q;
  assign busy     = busy_q;

  // Asynchronous read so the head can be loaded on the same edge it is popped.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
    full_d = (count_d == DEPTH_C);
    ovf_d  = ovf_q;
    if (clr_overflow) begin
      ovf_d = 1'b0;
    end
    if (wr_en && full_q) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  assign idx_d = idx_q + IDX_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (count_q != '0) begin
            shift_q <= mem_q[rd_ptr_q];
            baud_q  <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_q == BIT_LAST) begin
            baud_q  <= '0;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        S_DATA: begin
          if (baud_q == BIT_LAST) begin
            baud_q <= '0;
            if (idx_q == IDX_LAST) begin
`ifdef UART_TX_FIFO_PARITY_EN
              tx_q    <= (^shift_q) ^ PARITY_ODD;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              idx_q <= idx_d;
              tx_q  <= shift_q[idx_d];
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
`ifdef UART_TX_FIFO_PARITY_EN
        S_PARITY: begin
          if (baud_q == BIT_LAST) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
`endif
        S_STOP: begin
          if (baud_q == STOP_LAST) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
